coherence_ctrl: RTL and testbench
=================================

# coherence_ctrl

Bus-side coherence controller and memory arbiter for the dual-core MSI cache system. It is the responder for both cores' icache and dcache request ports and the initiator of their snoop ports (ccwait/ccinv/ccsnoopaddr). It serializes all cache traffic onto the single RAM port, issues snoops and invalidations, and routes dirty lines cache-to-cache while writing them back to RAM.

## Interface
- CPUS, 2, number of cores; only 2 is supported (core c, other core o = ~c).
- CLK  in  1  clock, all state on rising edge.
- RST  in  1  synchronous, active-high reset.
- iREN  in  2  icache read request per core.
- iaddr  in  2x32  icache word address per core.
- iwait  out  2  icache wait per core; low for one cycle = iload valid.
- iload  out  2x32  icache read data.
- dREN, dWEN  in  2 each  dcache read / write request per core.
- daddr, dstore  in  2x32 each  dcache word address / write data.
- cctrans, ccwrite  in  2 each  dcache coherence transaction / write-intent flags.
- dwait  out  2  dcache wait per core; low = current word done.
- dload  out  2x32  dcache read data.
- ccwait, ccinv  out  2 each  snoop hold / invalidate to each dcache.
- ccsnoopaddr  out  2x32  snoop address to each dcache.
- ramREN, ramWEN  out  1 each  RAM read / write strobe.
- ramaddr, ramstore  out  32 each  RAM address / write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3; word done only on ACCESS.

## Operation
- Registers: state, grant core g, ifetch flag, inv_q (captured ccwrite[g]), rr (round-robin pointer).
- Defaults, every state: iwait=2'b11, dwait=2'b11, ccwait=ccinv=0, ccsnoopaddr=0, iload=dload=0, ramREN=ramWEN=0, ramaddr=ramstore=0. acc = (ramstate==ACCESS).
- IDLE arbitration, first match wins. Each class is searched starting at core rr. rr <= ~g after any dcache grant.
  - dWEN[c] -> WB.
  - cctrans[c]&ccwrite[c]&~dREN[c]&~dWEN[c] -> INV.
  - dREN[c] -> SNOOP; inv_q <= ccwrite[c].
  - iREN[c] -> IF. Icache is lowest priority, with its own rr, flipped after each icache grant.
- WB: ramWEN=1, ramaddr=daddr[g], ramstore=dstore[g], dwait[g]=~acc. Locked to g while dWEN[g]. Exit to IDLE in the cycle dWEN[g]==0. This covers both 2-word writeback and 1-word halt dumps.
- INV, 1 cycle: ccinv[o]=1, ccsnoopaddr[o]=daddr[g], dwait[g]=0, no RAM access -> IDLE.
- SNOOP, 1 cycle: ccwait[o]=1, ccinv[o]=inv_q, ccsnoopaddr[o]=daddr[g] -> SNPCHK.
- SNPCHK, 1 cycle, same snoop outputs. If cctrans[o]&~ccwrite[o]&~dREN[o]&~dWEN[o] (o is forwarding) -> FWD0, else -> RD0.
- FWD0/FWD1: snoop outputs held.
  - dload[g]=dstore[o]. RAM writeback: ramWEN=1, ramaddr=daddr[o], ramstore=dstore[o].
  - dwait[g]=dwait[o]=~acc.
  - FWD0 -> FWD1 on acc. FWD1 -> IDLE on acc.
- RD0/RD1: ramREN=1, ramaddr=daddr[g], dload[g]=ramload, dwait[g]=~acc. RD0 -> RD1 on acc. RD1 -> IDLE on acc.
- IF: ramREN=1, ramaddr=iaddr[g], iload[g]=ramload, iwait[g]=~acc -> IDLE on acc.
- ERROR and BUSY are treated as not-done: hold state, no timeout.
- The requesting core never receives ccwait or ccinv from its own transaction.

## Timing
- Reset: state=IDLE, g=0, rr=0, inv_q=0, ifetch=0. All outputs take their default values in the cycle after RST is sampled high. Mid-transaction reset aborts with no further RAM strobes.
- Arbitration is registered; the first RAM strobe appears 1 cycle after the request.
- Read-miss latency: 2 snoop cycles + 2 RAM word accesses; grant-to-IDLE is at least 5 cycles.
- INV: request-to-ack is 2 cycles (grant, then INV cycle with dwait low).
- In FWD, the requester and forwarder see dwait low in the same cycle, so both advance word-aligned.
- Simultaneous events:
  - Same-class requests from both cores go to core rr.
  - dWEN on one core beats dREN on the other.
  - New requests are ignored outside IDLE.

## Test plan
- Reset: RST=1 for 2 cycles with all requests high -> dwait=iwait=2'b11, ccwait=ccinv=0, ramREN=ramWEN=0. Release -> first grant goes to core 0.
- Icache: iREN[0]=1, iaddr[0]=0x100, ACCESS on 3rd cycle, ramload=0xDEADBEEF -> ramaddr=0x100, iload[0]=0xDEADBEEF with iwait[0]=0 for exactly that cycle.
- Clean read miss: core0 dREN, daddr 0x200 then 0x204, core1 idle -> ccwait[1]=1 and ccsnoopaddr[1]=0x200 for 2 cycles, ccinv[1]=0, then ramREN reads 0x200 and 0x204 into dload[0].
- Forwarded miss: core1 drives FWD pattern in SNPCHK, dstore 0xAAAA then 0xBBBB -> dload[0]=0xAAAA/0xBBBB, ramWEN to 0x200/0x204, dwait[0]=dwait[1]=0 together on each ACCESS.
- Invalidate: core0 cctrans=ccwrite=1, daddr=0x300, no dREN/dWEN -> ccinv[1]=1 and ccsnoopaddr[1]=0x300 for one cycle with dwait[0]=0, no RAM strobe.
- Arbitration: core0 dREN and core1 dWEN in the same cycle -> core1 WB completes first. Then both dREN with rr=1 -> core1 served, then core0. A pending iREN waits until both dcache requests drop.

Source files
------------

// File: rtl/coherence_ctrl.sv
// Dual-core MSI coherence controller: serializes icache/dcache traffic onto one RAM port,
// snoops/invalidates the other dcache and forwards dirty lines cache-to-cache with writeback.
module coherence_ctrl #(
  parameter int CPUS = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [CPUS-1:0]           i_iREN,
  input  logic [CPUS-1:0][31:0]     i_iaddr,
  output logic [CPUS-1:0]           o_iwait,
  output logic [CPUS-1:0][31:0]     o_iload,
  input  logic [CPUS-1:0]           i_dREN,
  input  logic [CPUS-1:0]           i_dWEN,
  input  logic [CPUS-1:0][31:0]     i_daddr,
  input  logic [CPUS-1:0][31:0]     i_dstore,
  input  logic [CPUS-1:0]           i_cctrans,
  input  logic [CPUS-1:0]           i_ccwrite,
  output logic [CPUS-1:0]           o_dwait,
  output logic [CPUS-1:0][31:0]     o_dload,
  output logic [CPUS-1:0]           o_ccwait,
  output logic [CPUS-1:0]           o_ccinv,
  output logic [CPUS-1:0][31:0]     o_ccsnoopaddr,
  output logic                      o_ramREN,
  output logic                      o_ramWEN,
  output logic [31:0]               o_ramaddr,
  output logic [31:0]               o_ramstore,
  input  logic [31:0]               i_ramload,
  input  logic [1:0]                i_ramstate
);

  typedef enum logic [3:0] {
    S_IDLE, S_WB, S_INV, S_SNOOP, S_SNPCHK, S_FWD0, S_FWD1, S_RD0, S_RD1, S_IF
  } state_t;

  state_t      r_state, w_next, w_gState;
  logic        r_g, r_rr, r_irr, r_invq, r_ifetch;
  logic        w_o, w_acc, w_fwd;
  logic        w_dGrant, w_iGrant, w_gCore;
  logic [1:0]  w_dOrd, w_iOrd;
  logic [31:0] w_rdAddr;

  assign w_o      = ~r_g;
  assign w_acc    = (i_ramstate == 2'd2);
  assign w_fwd    = i_cctrans[w_o] & ~i_ccwrite[w_o] & ~i_dREN[w_o] & ~i_dWEN[w_o];
  assign w_dOrd   = {~r_rr, r_rr};
  assign w_iOrd   = {~r_irr, r_irr};
  assign w_rdAddr = r_ifetch ? i_iaddr[r_g] : i_daddr[r_g];

  // Classes are scanned from lowest priority up, and each in reverse search order,
  // so the last hit is the winner.
  always_comb begin
    w_dGrant = 1'b0;
    w_iGrant = 1'b0;
    w_gCore  = r_g;
    w_gState = S_IDLE;
    for (int k = 1; k >= 0; k--) begin
      if (i_iREN[w_iOrd[k]]) begin
        w_iGrant = 1'b1; w_dGrant = 1'b0; w_gCore = w_iOrd[k]; w_gState = S_IF;
      end
    end
    for (int k = 1; k >= 0; k--) begin
      if (i_dREN[w_dOrd[k]]) begin
        w_iGrant = 1'b0; w_dGrant = 1'b1; w_gCore = w_dOrd[k]; w_gState = S_SNOOP;
      end
    end
    for (int k = 1; k >= 0; k--) begin
      if (i_cctrans[w_dOrd[k]] & i_ccwrite[w_dOrd[k]] & ~i_dREN[w_dOrd[k]] & ~i_dWEN[w_dOrd[k]]) begin
        w_iGrant = 1'b0; w_dGrant = 1'b1; w_gCore = w_dOrd[k]; w_gState = S_INV;
      end
    end
    for (int k = 1; k >= 0; k--) begin
      if (i_dWEN[w_dOrd[k]]) begin
        w_iGrant = 1'b0; w_dGrant = 1'b1; w_gCore = w_dOrd[k]; w_gState = S_WB;
      end
    end
  end

  always_comb begin
    w_next        = r_state;
    o_iwait       = '1;
    o_dwait       = '1;
    o_iload       = '0;
    o_dload       = '0;
    o_ccwait      = '0;
    o_ccinv       = '0;
    o_ccsnoopaddr = '0;
    o_ramREN      = 1'b0;
    o_ramWEN      = 1'b0;
    o_ramaddr     = '0;
    o_ramstore    = '0;
    case (r_state)
      S_IDLE: begin
        if (w_dGrant | w_iGrant) w_next = w_gState;
      end
      S_WB: begin
        o_ramWEN       = 1'b1;
        o_ramaddr      = i_daddr[r_g];
        o_ramstore     = i_dstore[r_g];
        o_dwait[r_g]   = ~w_acc;
        if (!i_dWEN[r_g]) w_next = S_IDLE;
      end
      S_INV: begin
        o_ccinv[w_o]       = 1'b1;
        o_ccsnoopaddr[w_o] = i_daddr[r_g];
        o_dwait[r_g]       = 1'b0;
        w_next             = S_IDLE;
      end
      S_SNOOP, S_SNPCHK, S_FWD0, S_FWD1: begin
        o_ccwait[w_o]      = 1'b1;
        o_ccinv[w_o]       = r_invq;
        o_ccsnoopaddr[w_o] = i_daddr[r_g];
        if (r_state == S_SNOOP) begin
          w_next = S_SNPCHK;
        end else if (r_state == S_SNPCHK) begin
          w_next = w_fwd ? S_FWD0 : S_RD0;
        end else begin
          // Forwarder's word goes to the requester and to RAM in the same access.
          o_dload[r_g] = i_dstore[w_o];
          o_ramWEN     = 1'b1;
          o_ramaddr    = i_daddr[w_o];
          o_ramstore   = i_dstore[w_o];
          o_dwait[r_g] = ~w_acc;
          o_dwait[w_o] = ~w_acc;
          if (w_acc) w_next = (r_state == S_FWD0) ? S_FWD1 : S_IDLE;
        end
      end
      S_RD0, S_RD1, S_IF: begin
        o_ramREN  = 1'b1;
        o_ramaddr = w_rdAddr;
        if (r_ifetch) begin
          o_iload[r_g] = i_ramload;
          o_iwait[r_g] = ~w_acc;
        end else begin
          o_dload[r_g] = i_ramload;
          o_dwait[r_g] = ~w_acc;
        end
        if (w_acc) w_next = (r_state == S_RD0) ? S_RD1 : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_g      <= 1'b0;
      r_rr     <= 1'b0;
      r_irr    <= 1'b0;
      r_invq   <= 1'b0;
      r_ifetch <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && (w_dGrant | w_iGrant)) begin
        r_g      <= w_gCore;
        r_ifetch <= w_iGrant;
        if (w_dGrant) begin
          r_rr   <= ~w_gCore;
          r_invq <= i_ccwrite[w_gCore];
        end else begin
          r_irr  <= ~r_irr;
        end
      end
    end
  end

endmodule

// File: tb/tb_coherence_ctrl.sv
// Bench for coherence_ctrl: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_coherence_ctrl;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2;
  localparam logic [1:0] K_WB = 2'd0, K_INV = 2'd1, K_RD = 2'd2, K_IF = 2'd3;

  typedef struct packed {
    logic       valid;
    logic [1:0] kind;
    logic       core;
  } grant_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       iREN, dREN, dWEN, cctrans, ccwrite;
  logic [1:0][31:0] iaddr, daddr, dstore;
  logic [1:0]       iwait, dwait, ccwait, ccinv;
  logic [1:0][31:0] iload, dload, ccsnoopaddr;
  logic             ramREN, ramWEN;
  logic [31:0]      ramaddr, ramstore, ramload;
  logic [1:0]       ramstate;

  int nCompared = 0;
  int nMismatched = 0;

  coherence_ctrl #(.CPUS(2)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_iREN(iREN), .i_iaddr(iaddr), .o_iwait(iwait), .o_iload(iload),
    .i_dREN(dREN), .i_dWEN(dWEN), .i_daddr(daddr), .i_dstore(dstore),
    .i_cctrans(cctrans), .i_ccwrite(ccwrite),
    .o_dwait(dwait), .o_dload(dload),
    .o_ccwait(ccwait), .o_ccinv(ccinv), .o_ccsnoopaddr(ccsnoopaddr),
    .o_ramREN(ramREN), .o_ramWEN(ramWEN), .o_ramaddr(ramaddr), .o_ramstore(ramstore),
    .i_ramload(ramload), .i_ramstate(ramstate)
  );

  always #5 clk = ~clk;

  // Reference model: one outstanding transaction described by kind, owner core,
  // remaining snoop cycles, forward decision and words completed.
  logic       mValid = 1'b0;
  logic       mBusy = 1'b0;
  logic [1:0] mKind = K_WB;
  logic       mCore = 1'b0, mRr = 1'b0, mIrr = 1'b0, mInvQ = 1'b0, mFwd = 1'b0;
  int         mSnoop = 0, mWords = 0;
  logic       mOther, acc;
  grant_t     mPick;

  assign mOther = ~mCore;
  assign acc    = (ramstate == ACCESS);

  function automatic grant_t pickGrant(input logic [1:0] wen, ren, trans, wr, iren,
                                       input logic rr, irr);
    grant_t gr;
    gr = '0;
    for (int k = 0; k < 2; k++) begin
      logic c;
      c = rr ^ k[0];
      if (!gr.valid && wen[c]) begin gr.valid = 1'b1; gr.kind = K_WB; gr.core = c; end
    end
    for (int k = 0; k < 2; k++) begin
      logic c;
      c = rr ^ k[0];
      if (!gr.valid && trans[c] && wr[c] && !ren[c] && !wen[c]) begin
        gr.valid = 1'b1; gr.kind = K_INV; gr.core = c;
      end
    end
    for (int k = 0; k < 2; k++) begin
      logic c;
      c = rr ^ k[0];
      if (!gr.valid && ren[c]) begin gr.valid = 1'b1; gr.kind = K_RD; gr.core = c; end
    end
    for (int k = 0; k < 2; k++) begin
      logic c;
      c = irr ^ k[0];
      if (!gr.valid && iren[c]) begin gr.valid = 1'b1; gr.kind = K_IF; gr.core = c; end
    end
    return gr;
  endfunction

  assign mPick = pickGrant(dWEN, dREN, cctrans, ccwrite, iREN, mRr, mIrr);

  always @(posedge clk) begin
    if (rst) begin
      mValid <= 1'b1; mBusy <= 1'b0; mCore <= 1'b0; mRr <= 1'b0; mIrr <= 1'b0; mInvQ <= 1'b0;
    end else if (!mBusy) begin
      if (mPick.valid) begin
        mBusy <= 1'b1; mKind <= mPick.kind; mCore <= mPick.core;
        mSnoop <= 2; mFwd <= 1'b0; mWords <= 0;
        if (mPick.kind == K_IF) mIrr <= ~mIrr;
        else mRr <= ~mPick.core;
        if (mPick.kind == K_RD) mInvQ <= ccwrite[mPick.core];
      end
    end else begin
      case (mKind)
        K_WB:  if (!dWEN[mCore]) mBusy <= 1'b0;
        K_INV: mBusy <= 1'b0;
        K_RD: begin
          if (mSnoop > 0) begin
            mSnoop <= mSnoop - 1;
            if (mSnoop == 1)
              mFwd <= cctrans[mOther] && !ccwrite[mOther] && !dREN[mOther] && !dWEN[mOther];
          end else if (acc) begin
            mWords <= mWords + 1;
            if (mWords == 1) mBusy <= 1'b0;
          end
        end
        default: if (acc) mBusy <= 1'b0;
      endcase
    end
  end

  logic [1:0]       eIwait, eDwait, eCcwait, eCcinv;
  logic [1:0][31:0] eIload, eDload, eSnoop;
  logic             eRamREN, eRamWEN;
  logic [31:0]      eRamaddr, eRamstore;

  always_comb begin
    eIwait = '1; eDwait = '1; eIload = '0; eDload = '0; eCcwait = '0; eCcinv = '0;
    eSnoop = '0; eRamREN = 1'b0; eRamWEN = 1'b0; eRamaddr = '0; eRamstore = '0;
    if (mBusy) begin
      case (mKind)
        K_WB: begin
          eRamWEN = 1'b1; eRamaddr = daddr[mCore]; eRamstore = dstore[mCore];
          eDwait[mCore] = ~acc;
        end
        K_INV: begin
          eCcinv[mOther] = 1'b1; eSnoop[mOther] = daddr[mCore]; eDwait[mCore] = 1'b0;
        end
        K_RD: begin
          if (mSnoop > 0 || mFwd) begin
            eCcwait[mOther] = 1'b1; eCcinv[mOther] = mInvQ; eSnoop[mOther] = daddr[mCore];
          end
          if (mSnoop == 0 && mFwd) begin
            eDload[mCore] = dstore[mOther];
            eRamWEN = 1'b1; eRamaddr = daddr[mOther]; eRamstore = dstore[mOther];
            eDwait = acc ? 2'b00 : 2'b11;
          end else if (mSnoop == 0) begin
            eRamREN = 1'b1; eRamaddr = daddr[mCore];
            eDload[mCore] = ramload; eDwait[mCore] = ~acc;
          end
        end
        default: begin
          eRamREN = 1'b1; eRamaddr = iaddr[mCore];
          eIload[mCore] = ramload; eIwait[mCore] = ~acc;
        end
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mValid) begin
      checkOutput("iwait", 64'(iwait), 64'(eIwait));
      checkOutput("iload", iload, eIload);
      checkOutput("dwait", 64'(dwait), 64'(eDwait));
      checkOutput("dload", dload, eDload);
      checkOutput("ccwait", 64'(ccwait), 64'(eCcwait));
      checkOutput("ccinv", 64'(ccinv), 64'(eCcinv));
      checkOutput("ccsnoopaddr", ccsnoopaddr, eSnoop);
      checkOutput("ramREN", 64'(ramREN), 64'(eRamREN));
      checkOutput("ramWEN", 64'(ramWEN), 64'(eRamWEN));
      checkOutput("ramaddr", 64'(ramaddr), 64'(eRamaddr));
      checkOutput("ramstore", 64'(ramstore), 64'(eRamstore));
    end
  end

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // Entered in an IDLE cycle where core g's dREN wins at the coming edge.
  task automatic serveRead(input int g, input logic [31:0] addr, input logic [31:0] w0,
                           input logic [31:0] w1, input logic fwd);
    int o;
    logic [1:0] doneMask;
    o = 1 - g;
    doneMask = fwd ? 2'b00 : ((g == 0) ? 2'b10 : 2'b01);
    applyStimulus();
    #1;
    checkOutput("snoop_ccwait", 64'(ccwait), (o == 1) ? 64'h2 : 64'h1);
    checkOutput("snoop_addr", 64'(ccsnoopaddr[o]), 64'(addr));
    if (fwd) begin cctrans[o] = 1'b1; ccwrite[o] = 1'b0; daddr[o] = addr; dstore[o] = w0; end
    applyStimulus();
    applyStimulus();
    ramstate = ACCESS;
    if (!fwd) ramload = w0;
    #1;
    checkOutput("word0_dload", 64'(dload[g]), 64'(w0));
    checkOutput("word0_dwait", 64'(dwait), 64'(doneMask));
    checkOutput("word0_ramaddr", 64'(ramaddr), 64'(addr));
    checkOutput("word0_strobe", 64'({ramREN, ramWEN}), fwd ? 64'h1 : 64'h2);
    applyStimulus();
    daddr[g] = addr + 32'd4;
    if (fwd) begin daddr[o] = addr + 32'd4; dstore[o] = w1; end
    else ramload = w1;
    ramstate = BUSY;
    #1;
    checkOutput("word1_hold", 64'(dwait), 64'h3);
    applyStimulus();
    ramstate = ACCESS;
    #1;
    checkOutput("word1_dload", 64'(dload[g]), 64'(w1));
    checkOutput("word1_ramaddr", 64'(ramaddr), 64'(addr + 32'd4));
    if (fwd) checkOutput("word1_ramstore", 64'(ramstore), 64'(w1));
    applyStimulus();
    dREN[g] = 1'b0; daddr[g] = '0; ramstate = FREE; ramload = '0;
    if (fwd) begin cctrans[o] = 1'b0; daddr[o] = '0; dstore[o] = '0; end
    #1;
    checkOutput("read_done_dwait", 64'(dwait), 64'h3);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    iREN = '1; dREN = '1; dWEN = '1; cctrans = '1; ccwrite = '1;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    applyStimulus();
    applyStimulus();
    #1;
    checkOutput("rst_dwait", 64'(dwait), 64'h3);
    checkOutput("rst_iwait", 64'(iwait), 64'h3);
    checkOutput("rst_ccwait", 64'(ccwait), 64'h0);
    checkOutput("rst_ccinv", 64'(ccinv), 64'h0);
    checkOutput("rst_ramstrobe", 64'({ramREN, ramWEN}), 64'h0);

    $display("[TB] release reset, both cores read");
    rst = 1'b0; iREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
    dREN = 2'b11; daddr[0] = 32'h200; daddr[1] = 32'h500;
    serveRead(0, 32'h200, 32'h11111111, 32'h22222222, 1'b0);
    serveRead(1, 32'h500, 32'h33333333, 32'h44444444, 1'b0);

    $display("[TB] icache fetch");
    iREN[0] = 1'b1; iaddr[0] = 32'h100;
    applyStimulus();
    ramstate = BUSY;
    #1;
    checkOutput("if_wait", 64'(iwait), 64'h3);
    applyStimulus();
    applyStimulus();
    ramstate = ACCESS; ramload = 32'hDEADBEEF;
    #1;
    checkOutput("if_ramaddr", 64'(ramaddr), 64'h100);
    checkOutput("if_iload", 64'(iload[0]), 64'hDEADBEEF);
    checkOutput("if_iwait", 64'(iwait), 64'h2);
    applyStimulus();
    iREN = '0; iaddr = '0; ramstate = FREE; ramload = '0;
    #1;
    checkOutput("if_done", 64'(iwait), 64'h3);

    $display("[TB] clean and forwarded read miss");
    dREN[0] = 1'b1; daddr[0] = 32'h200;
    serveRead(0, 32'h200, 32'h5555AAAA, 32'h6666BBBB, 1'b0);
    dREN[0] = 1'b1; daddr[0] = 32'h200;
    serveRead(0, 32'h200, 32'h0000AAAA, 32'h0000BBBB, 1'b1);

    $display("[TB] invalidate");
    cctrans[0] = 1'b1; ccwrite[0] = 1'b1; daddr[0] = 32'h300;
    applyStimulus();
    #1;
    checkOutput("inv_ccinv", 64'(ccinv), 64'h2);
    checkOutput("inv_addr", 64'(ccsnoopaddr[1]), 64'h300);
    checkOutput("inv_dwait", 64'(dwait), 64'h2);
    checkOutput("inv_strobe", 64'({ramREN, ramWEN}), 64'h0);
    cctrans[0] = 1'b0; ccwrite[0] = 1'b0; daddr[0] = '0;
    applyStimulus();
    #1;
    checkOutput("inv_done", 64'(ccinv), 64'h0);

    $display("[TB] writeback beats read");
    dREN[0] = 1'b1; daddr[0] = 32'h400;
    dWEN[1] = 1'b1; daddr[1] = 32'h600; dstore[1] = 32'h66;
    applyStimulus();
    ramstate = ACCESS;
    #1;
    checkOutput("wb0_ramaddr", 64'(ramaddr), 64'h600);
    checkOutput("wb0_ramstore", 64'(ramstore), 64'h66);
    checkOutput("wb0_dwait", 64'(dwait), 64'h1);
    applyStimulus();
    daddr[1] = 32'h604; dstore[1] = 32'h67;
    #1;
    checkOutput("wb1_ramaddr", 64'(ramaddr), 64'h604);
    applyStimulus();
    dWEN[1] = 1'b0; daddr[1] = '0; dstore[1] = '0; ramstate = FREE;
    applyStimulus();
    serveRead(0, 32'h400, 32'h0A0A0A0A, 32'h0B0B0B0B, 1'b0);

    $display("[TB] both reads with rr at core 1, icache pending");
    dREN = 2'b11; daddr[0] = 32'h700; daddr[1] = 32'h800;
    iREN[1] = 1'b1; iaddr[1] = 32'h900;
    serveRead(1, 32'h800, 32'hC0C0C0C0, 32'hC1C1C1C1, 1'b0);
    serveRead(0, 32'h700, 32'hD0D0D0D0, 32'hD1D1D1D1, 1'b0);
    applyStimulus();
    ramstate = ACCESS; ramload = 32'h12345678;
    #1;
    checkOutput("if1_ramaddr", 64'(ramaddr), 64'h900);
    checkOutput("if1_iload", 64'(iload[1]), 64'h12345678);
    checkOutput("if1_iwait", 64'(iwait), 64'h1);
    applyStimulus();
    iREN = '0; iaddr = '0; ramstate = FREE; ramload = '0;

    $display("[TB] reset mid-transaction");
    dREN[0] = 1'b1; daddr[0] = 32'h200;
    applyStimulus();
    applyStimulus();
    applyStimulus();
    ramstate = BUSY;
    #1;
    checkOutput("midrst_before", 64'(ramREN), 64'h1);
    rst = 1'b1; dREN = '0; daddr = '0;
    applyStimulus();
    #1;
    checkOutput("midrst_strobe", 64'({ramREN, ramWEN}), 64'h0);
    checkOutput("midrst_ccwait", 64'(ccwait), 64'h0);
    rst = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("post_rst_strobe", 64'({ramREN, ramWEN}), 64'h0);
    applyStimulus();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
